// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
//   Shared definitions for the 32x256 1RW1R OpenRAM initiator controller.
//   Holds the macro geometry defaults and the port-0 request bundle so the
//   top level can treat a port-0 request as one packed value.
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned SRAM_ADDR_WIDTH = 8;
  localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;

  // Everything the macro needs to see on port 0 for one access.
  typedef struct packed {
    logic                       we;
    logic [SRAM_NUM_WMASKS-1:0] wmask;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
  } p0_req_t;

endpackage : sram_ctrl_pkg

// File: rtl/sram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// sram_rsp_fifo
//   Small response FIFO sitting behind one macro read port. When empty, the
//   word being pushed is presented on the output in the same cycle (bypass),
//   so a read returns one cycle after it is issued.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   push_i       macro read data is valid this cycle
//   push_data_i  macro read data
//   pop_i        consumer takes the head word (only honoured when valid_o)
//   valid_o      head word (stored or bypassed) is available
//   data_o       head word
//   count_o      number of words held in storage (bypass word not counted)
// ---------------------------------------------------------------------------
module sram_rsp_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter int unsigned CNTW       = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNTW-1:0]       count_o
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  empty;
  logic                  do_pop;
  logic                  store;
  logic                  deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign valid_o = !empty || push_i;
  assign data_o  = empty ? push_data_i : mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_pop = pop_i && valid_o;
  // A word pushed into an empty FIFO and popped in the same cycle flows
  // straight through and never occupies storage.
  assign store  = push_i && !(empty && do_pop);
  assign deq    = do_pop && !empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNTW'(store) - CNTW'(deq);
    if (store) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq)   rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the data array is deliberately not reset; the count gates every
  // read of it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : sram_rsp_fifo

// File: rtl/sram_1rw1r_ctrl.sv
// ---------------------------------------------------------------------------
// sram_1rw1r_ctrl
//   Initiator-side controller for the 32x256 1RW1R OpenRAM macro. Two
//   valid/ready request channels drive macro port 0 (read/write) and port 1
//   (read only) combinationally; read data returned one cycle later is
//   captured into a per-port response FIFO. Credits keep each FIFO from
//   overflowing. A port-1 read to the address port 0 is writing this cycle
//   is stalled one cycle and counted.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   p0_valid/ready/we/wmask/addr/wdata   port-0 request channel
//   p0_rsp_valid/ready/data        port-0 read response channel
//   p1_valid/ready/addr            port-1 read request channel
//   p1_rsp_valid/ready/data        port-1 read response channel
//   sram_csb0/web0/wmask0/addr0/din0/dout0   macro port 0
//   sram_csb1/addr1/dout1          macro port 1
//   collision_cnt                  saturating count of stalled port-1 cycles
// ---------------------------------------------------------------------------
module sram_1rw1r_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [NUM_WMASKS-1:0] p0_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_data,

  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_data,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,

  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,

  output logic [CNT_WIDTH-1:0]  collision_cnt
);

  localparam int unsigned CNTW = $clog2(RSP_DEPTH + 1);
  // One extra bit so occupancy + limit comparisons never wrap.
  localparam int unsigned CW   = CNTW + 1;

  // ---------------- port 0 ----------------
  p0_req_t          p0_req;
  p0_req_t          p0_issue;
  logic             p0_inflight_q, p0_inflight_d;
  logic             p0_fifo_valid;
  logic [CNTW-1:0]  p0_count;
  logic             p0_pop;
  logic             p0_credit;
  logic             p0_accept;

  // ---------------- port 1 ----------------
  logic             p1_inflight_q, p1_inflight_d;
  logic             p1_fifo_valid;
  logic [CNTW-1:0]  p1_count;
  logic             p1_pop;
  logic             p1_credit;
  logic             p1_accept;

  logic                 collision;
  logic [CNT_WIDTH-1:0] coll_cnt_q, coll_cnt_d;

  // Responses are suppressed during reset: a read in flight when rst rises
  // must never surface, even though its inflight flag is still set.
  assign p0_rsp_valid = p0_fifo_valid && !rst;
  assign p1_rsp_valid = p1_fifo_valid && !rst;
  assign p0_pop       = p0_rsp_valid && p0_rsp_ready;
  assign p1_pop       = p1_rsp_valid && p1_rsp_ready;

  // A new read is allowed only if every outstanding word (in flight or
  // stored) still has a FIFO slot once this cycle's pop is accounted for.
  assign p0_credit = (CW'(p0_count) + CW'(p0_inflight_q)) <
                     (CW'(RSP_DEPTH) + CW'(p0_pop));
  assign p1_credit = (CW'(p1_count) + CW'(p1_inflight_q)) <
                     (CW'(RSP_DEPTH) + CW'(p1_pop));

  // Writes return nothing, so they bypass the credit check.
  assign p0_ready  = !rst && (p0_we || p0_credit);
  assign p0_accept = p0_valid && p0_ready;

  // The macro reads port 1 and writes port 0 at the same edge; a same-address
  // pair would return undefined data, so the port-1 read waits a cycle.
  assign collision = p0_accept && p0_we && p1_valid && (p1_addr == p0_addr);

  assign p1_ready  = !rst && p1_credit && !collision;
  assign p1_accept = p1_valid && p1_ready;

  assign p0_inflight_d = p0_accept && !p0_we;
  assign p1_inflight_d = p1_accept;

  // Macro drive is combinational: the macro itself registers its inputs.
  assign p0_req   = '{we: p0_we, wmask: p0_wmask, addr: p0_addr, wdata: p0_wdata};
  assign p0_issue = p0_accept ? p0_req : '0;

  assign sram_csb0   = !p0_accept;
  assign sram_web0   = !p0_issue.we;
  assign sram_wmask0 = p0_issue.we ? p0_issue.wmask : '0;
  assign sram_addr0  = p0_issue.addr;
  assign sram_din0   = p0_issue.we ? p0_issue.wdata : '0;

  assign sram_csb1   = !p1_accept;
  assign sram_addr1  = p1_accept ? p1_addr : '0;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (collision && (coll_cnt_q != '1)) coll_cnt_d = coll_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_inflight_q <= 1'b0;
      p1_inflight_q <= 1'b0;
      coll_cnt_q    <= '0;
    end else begin
      p0_inflight_q <= p0_inflight_d;
      p1_inflight_q <= p1_inflight_d;
      coll_cnt_q    <= coll_cnt_d;
    end
  end

  assign collision_cnt = coll_cnt_q;

  // Read data appears on doutX the cycle after issue; capture it then.
  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH),
    .CNTW       (CNTW)
  ) u_p0_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (p0_inflight_q && !rst),
    .push_data_i (sram_dout0),
    .pop_i       (p0_pop),
    .valid_o     (p0_fifo_valid),
    .data_o      (p0_rsp_data),
    .count_o     (p0_count)
  );

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH),
    .CNTW       (CNTW)
  ) u_p1_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (p1_inflight_q && !rst),
    .push_data_i (sram_dout1),
    .pop_i       (p1_pop),
    .valid_o     (p1_fifo_valid),
    .data_o      (p1_rsp_data),
    .count_o     (p1_count)
  );

endmodule : sram_1rw1r_ctrl

// File: tb/tb_sram_1rw1r_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_1rw1r_ctrl
//   Directed bench for sram_1rw1r_ctrl with a behavioural 1RW1R macro model
//   (inputs registered on clk, read data valid the following cycle).
// ---------------------------------------------------------------------------
module tb_sram_1rw1r_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int WM = 4;
  localparam int CNTW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p0_ready, p0_we;
  logic [WM-1:0] p0_wmask;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_rsp_valid, p0_rsp_ready;
  logic [DW-1:0] p0_rsp_data;
  logic          p1_valid, p1_ready;
  logic [AW-1:0] p1_addr;
  logic          p1_rsp_valid, p1_rsp_ready;
  logic [DW-1:0] p1_rsp_data;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [WM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;
  logic [CNTW-1:0] collision_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_1rw1r_ctrl dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
    .p0_wmask(p0_wmask), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_data(p0_rsp_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_data(p1_rsp_data),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
    .collision_cnt(collision_cnt)
  );

  // Behavioural macro: registered inputs, read data one cycle later.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < WM; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    p0_valid = 1'b0; p0_we = 1'b0; p0_wmask = '0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_addr = '0;
  endtask

  task automatic p0_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [WM-1:0] m);
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = a; p0_wdata = d; p0_wmask = m;
  endtask

  task automatic p0_read(input logic [AW-1:0] a);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = a; p0_wdata = '0; p0_wmask = '0;
  endtask

  int sent, got, acc;
  logic [DW-1:0] exp_q [$];

  initial begin
    idle();
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    // Reset state, with requests presented so ready gating is exercised.
    p0_read(8'h33);
    p1_valid = 1'b1; p1_addr = 8'h33;
    #1;
    check("rst_p0_ready", p0_ready, 0);
    check("rst_p1_ready", p1_ready, 0);
    check("rst_csb0", sram_csb0, 1);
    check("rst_csb1", sram_csb1, 1);
    check("rst_web0", sram_web0, 1);
    check("rst_wmask0", sram_wmask0, 0);
    step();
    check("rst_cnt", collision_cnt, 0);
    check("rst_p0_rsp_valid", p0_rsp_valid, 0);
    check("rst_p1_rsp_valid", p1_rsp_valid, 0);
    idle();
    rst = 1'b0;
    step();

    // --- Write then p0 read ---
    p0_write(8'h10, 32'hDEADBEEF, 4'hF);
    #1;
    check("wr_ready", p0_ready, 1);
    check("wr_csb0", sram_csb0, 0);
    check("wr_web0", sram_web0, 0);
    check("wr_addr0", sram_addr0, 8'h10);
    check("wr_din0", sram_din0, 32'hDEADBEEF);
    step();
    p0_read(8'h10);
    #1;
    check("rd_csb0", sram_csb0, 0);
    check("rd_web0", sram_web0, 1);
    check("rd_no_early_rsp", p0_rsp_valid, 0);
    step();
    idle();
    #1;
    check("rd_csb0_idle", sram_csb0, 1);
    check("rd_rsp_valid", p0_rsp_valid, 1);
    check("rd_rsp_data", p0_rsp_data, 32'hDEADBEEF);
    step();
    #1;
    check("rd_rsp_gone", p0_rsp_valid, 0);

    // --- Byte-mask writes then p1 read ---
    @(negedge clk);
    p0_write(8'h20, 32'h11223344, 4'hF);
    step();
    p0_write(8'h20, 32'hAABBCCDD, 4'b0101);
    #1;
    check("mask_wmask0", sram_wmask0, 4'b0101);
    step();
    // Zero-mask write is still issued; it must not alter 0x20.
    p0_write(8'h20, 32'hFFFFFFFF, 4'h0);
    #1;
    check("mask0_csb0", sram_csb0, 0);
    check("mask0_web0", sram_web0, 0);
    step();
    idle();
    p1_valid = 1'b1; p1_addr = 8'h20;
    #1;
    check("mask_p1_ready", p1_ready, 1);
    check("mask_csb1", sram_csb1, 0);
    step();
    idle();
    #1;
    check("mask_rsp_valid", p1_rsp_valid, 1);
    check("mask_rsp_data", p1_rsp_data, 32'h11BB33DD);
    step();

    // --- Streaming 8 p1 reads with backpressure ---
    for (int i = 0; i < 8; i++) begin
      p0_write(8'h40 + 8'(i), 32'h0B0B0000 + i, 4'hF);
      exp_q.push_back(32'h0B0B0000 + i);
      step();
    end
    idle();
    p1_rsp_ready = 1'b0;
    sent = 0; acc = 0; got = 0;
    for (int c = 0; c < 5; c++) begin
      p1_valid = 1'b1; p1_addr = 8'h40 + 8'(sent);
      #1;
      if (p1_ready) sent++;
      step();
    end
    #1;
    check("bp_accepts", sent, 2);
    check("bp_ready_low", p1_ready, 0);
    p1_rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      p1_valid = (sent < 8); p1_addr = 8'h40 + 8'(sent);
      #1;
      if (p1_valid && p1_ready) acc = 1; else acc = 0;
      if (p1_rsp_valid) begin
        check($sformatf("stream_%0d", got), p1_rsp_data, exp_q.pop_front());
        got++;
      end
      step();
      sent += acc;
    end
    idle();
    #1;
    check("stream_count", got, 8);
    check("stream_drained", p1_rsp_valid, 0);
    @(negedge clk);

    // --- Collision ---
    p0_write(8'h05, 32'hCAFE0005, 4'hF);
    p1_valid = 1'b1; p1_addr = 8'h05;
    #1;
    check("coll_p0_ready", p0_ready, 1);
    check("coll_p1_ready", p1_ready, 0);
    check("coll_csb1", sram_csb1, 1);
    step();
    p0_valid = 1'b0;
    #1;
    check("coll_cnt1", collision_cnt, 1);
    check("coll_retry_ready", p1_ready, 1);
    step();
    idle();
    #1;
    check("coll_rsp_valid", p1_rsp_valid, 1);
    check("coll_rsp_data", p1_rsp_data, 32'hCAFE0005);
    step();

    // --- Reset mid-read ---
    p0_read(8'h10);
    #1;
    check("rmr_accept", p0_ready, 1);
    step();
    idle();
    rst = 1'b1;
    #1;
    check("rmr_no_rsp_in_rst", p0_rsp_valid, 0);
    check("rmr_csb0", sram_csb0, 1);
    check("rmr_csb1", sram_csb1, 1);
    step();
    rst = 1'b0;
    #1;
    check("rmr_cnt", collision_cnt, 0);
    check("rmr_no_rsp", p0_rsp_valid, 0);
    step();
    #1;
    check("rmr_no_rsp2", p0_rsp_valid, 0);
    @(negedge clk);
    p0_read(8'h10);
    step();
    idle();
    #1;
    check("rmr_after_valid", p0_rsp_valid, 1);
    check("rmr_after_data", p0_rsp_data, 32'hDEADBEEF);
    step();

    // --- Saturation: 2^16 + 3 collision cycles ---
    p0_write(8'h05, 32'h12345678, 4'hF);
    p1_valid = 1'b1; p1_addr = 8'h05;
    for (int i = 0; i < 3; i++) step();
    #1;
    check("sat_cnt3", collision_cnt, 3);
    for (int i = 0; i < 65536; i++) step();
    #1;
    check("sat_cnt_max", collision_cnt, 16'hFFFF);
    check("sat_p1_stalled", p1_ready, 0);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sram_1rw1r_ctrl

// File: doc/sram_1rw1r_ctrl.md
Name: sram_1rw1r_ctrl

Overview:
- Initiator-side controller for the 32x256 1RW1R OpenRAM macro used by the BRAM tile.
- Converts two valid/ready request channels into macro port 0 (RW) and port 1 (R) strobes, and captures macro read data one cycle later into per-port response FIFOs with backpressure.
- Stalls port-1 reads that collide with a same-address port-0 write.
- The macro's clk0 and clk1 are tied to clk at the parent level.

Parameters:
- DATA_WIDTH, 32, word width; must equal the macro word width.
- ADDR_WIDTH, 8, word address width.
- NUM_WMASKS, 4, byte-lane write-mask bits; DATA_WIDTH/8.
- RSP_DEPTH, 2, entries per response FIFO; minimum 2 for full throughput.
- CNT_WIDTH, 16, width of the saturating collision counter.

Ports:
- clk  in  1  single clock; rising-edge logic.
- rst  in  1  synchronous, active-high reset.
- p0_valid  in  1  port-0 request valid.
- p0_ready  out  1  port-0 request accepted when valid&&ready.
- p0_we  in  1  1 = write, 0 = read.
- p0_wmask  in  NUM_WMASKS  byte enables for writes.
- p0_addr  in  ADDR_WIDTH  port-0 word address.
- p0_wdata  in  DATA_WIDTH  write data.
- p0_rsp_valid  out  1  port-0 read data available.
- p0_rsp_ready  in  1  port-0 response consumed.
- p0_rsp_data  out  DATA_WIDTH  port-0 read data.
- p1_valid  in  1  port-1 read request valid.
- p1_ready  out  1  port-1 request accepted.
- p1_addr  in  ADDR_WIDTH  port-1 word address.
- p1_rsp_valid  out  1  port-1 read data available.
- p1_rsp_ready  in  1  port-1 response consumed.
- p1_rsp_data  out  DATA_WIDTH  port-1 read data.
- sram_csb0  out  1  macro port-0 chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  NUM_WMASKS  macro write mask.
- sram_addr0  out  ADDR_WIDTH  macro port-0 address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro port-0 read data.
- sram_csb1  out  1  macro port-1 chip select, active low.
- sram_addr1  out  ADDR_WIDTH  macro port-1 address.
- sram_dout1  in  DATA_WIDTH  macro port-1 read data.
- collision_cnt  out  CNT_WIDTH  saturating count of stalled port-1 cycles.

Behaviour:
- Reset: rst is synchronous and active-high on clk. While rst=1:
  - p0_ready=0, p1_ready=0, p0_rsp_valid=0, p1_rsp_valid=0.
  - sram_csb0=1, sram_csb1=1, sram_web0=1, sram_wmask0=0, collision_cnt=0.
  - FIFOs and in-flight flags are cleared. Reads in flight at reset are dropped; no response is ever produced for them.
- Macro drive is combinational from the accepted request, because the macro registers its inputs on clk.
  - sram_csb0 = !(p0_valid&&p0_ready); sram_web0 = !p0_we; sram_wmask0/addr0/din0 pass through.
  - Same scheme for port 1.
  - When a port is idle, its csb is 1 and its other outputs are don't-care; hold them at 0.
- Read latency: a read accepted in cycle N sets that port's inflight flag. In cycle N+1, sram_doutX is pushed into that port's FIFO and inflight clears.
  - An accepted read reaches rsp_valid=1 at the earliest in cycle N+1, via a combinational bypass when the FIFO is empty; otherwise FIFO order is kept.
  - Back-to-back reads give one response per cycle.
- Credit rule per port: ready only if inflight + fifo_count − pop < RSP_DEPTH, where pop = rsp_valid&&rsp_ready this cycle. Response data is therefore never lost.
- Writes: p0 writes consume no credit and produce no response. p0_ready for a write equals !rst.
  - A write with wmask=0 is still issued (csb0=0, web0=0).
- Collision: if port 0 accepts a write and p1_valid is high with p1_addr==p0_addr, then p1_ready=0 that cycle and collision_cnt increments, saturating at all-ones.
  - Port-0 reads never collide.
  - A port-1 read issued in the cycle after a write returns the newly written data.
- Ordering: each port returns responses in request order. Ports are independent; there is no ordering between ports.
- No FSM beyond inflight/FIFO counters. States per port: IDLE (no inflight, FIFO empty), BUSY (inflight or FIFO non-empty), FULL (credits exhausted, ready=0).

Decomposition:
- Package sram_ctrl_pkg: DATA_WIDTH/ADDR_WIDTH/NUM_WMASKS defaults, and a typedef for the port-0 request struct (we, wmask, addr, wdata).
- Sub-module sram_rsp_fifo (RSP_DEPTH entries, push/pop, count, empty-bypass), instantiated once per port.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with wmask=4'hF, then p0 read of 0x10 → p0_rsp_valid in the next cycle with data 0xDEADBEEF; sram_csb0 is low exactly one cycle per request.
- Byte-mask write: 0x11223344 to 0x20 with mask 4'hF, then 0xAABBCCDD with mask 4'b0101, then p1 read of 0x20 → 0x11BB33DD.
- Streaming with backpressure: 8 consecutive p1 reads with p1_rsp_ready held low → p1_ready drops after 2 accepts. Releasing ready returns all 8 values in order, with no loss or duplication.
- Collision: p0 write to 0x05 and p1 read of 0x05 in the same cycle → p1_ready=0, collision_cnt=1. The p1 read is accepted the next cycle and returns the new data.
- Reset mid-read: assert rst the cycle after p0 read acceptance → no p0_rsp_valid, all csb=1, collision_cnt=0. After rst drops, normal reads work.
- Saturation: force 2^CNT_WIDTH+3 collision cycles → collision_cnt holds 0xFFFF.
